// File: rtl/absminmax_seq.sv
// Command-driven sequencer for the shared 16-bit abs/min/max datapath.
// It folds a burst of streamed samples into a single accumulator and returns one result word.
module absminmax_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_data,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [15:0]      r_data,
    output logic [LEN_W-1:0] r_count,
    output logic             r_err,
    output logic [15:0]      dp_a,
    output logic [15:0]      dp_b,
    output logic [1:0]       dp_c,
    input  logic [15:0]      dp_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MAXC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MAXABS = 2'b00;
    localparam logic [1:0] OP_MIN    = 2'b01;
    localparam logic [1:0] OP_MAX    = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      acc;
    logic [15:0]      tmp;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       op;

    logic s_hs;
    logic last;
    logic cmd_hs;

    // Ready/valid strobes come from registered state only; s_valid never reaches s_ready.
    assign cmd_hs = (state == IDLE) && cmd_valid;
    assign s_hs   = (state == RUN) && s_valid;
    assign last   = (remaining == LEN_ONE);
    assign r_data = acc;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_RSVD || cmd_len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (s_valid) begin
                    if (op == OP_MAXABS) begin
                        state_nxt = MAXC;
                    end else if (last) begin
                        state_nxt = DONE;
                    end
                end
            end
            MAXC: begin
                state_nxt = last ? DONE : RUN;
            end
            DONE: begin
                if (r_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: handshake strobes and datapath operand steering.
    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        r_valid   = 1'b0;
        dp_a      = 16'h0000;
        dp_b      = 16'h0000;
        dp_c      = OP_RSVD;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            RUN: begin
                s_ready = 1'b1;
                dp_a    = acc;
                dp_b    = s_data;
                dp_c    = (op == OP_MAXABS) ? OP_MAXABS : op;
            end
            MAXC: begin
                // Second half of a MAXABS step: compare stored |sample| against acc.
                dp_a = acc;
                dp_b = tmp;
                dp_c = OP_MAX;
            end
            DONE: begin
                r_valid = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Accumulator, burst bookkeeping and result status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 16'h0000;
            tmp       <= 16'h0000;
            remaining <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            op        <= OP_MAXABS;
        end else begin
            if (cmd_hs) begin
                op      <= cmd_op;
                r_count <= '0;
                r_err   <= (cmd_op == OP_RSVD);
                acc     <= (cmd_op == OP_MIN) ? 16'hFFFF : 16'h0000;
                remaining <= (cmd_op == OP_RSVD) ? '0 : cmd_len;
            end else if (s_hs) begin
                r_count <= r_count + LEN_ONE;
                if (op == OP_MAXABS) begin
                    tmp <= dp_out;
                end else begin
                    acc       <= dp_out;
                    remaining <= remaining - LEN_ONE;
                end
            end else if (state == MAXC) begin
                acc       <= dp_out;
                remaining <= remaining - LEN_ONE;
            end
        end
    end

endmodule

// File: doc/absminmax_seq.md
Name: absminmax_seq

Overview:
- Command-driven sequencer for the shared 16-bit abs/min/max datapath unit.
- Accepts a reduction command (op, length), pulls that many samples from a valid/ready stream, and drives the datapath each cycle to fold them into one accumulator.
- Returns a single result word over a valid/ready result port.
- Sits between the sample source and the datapath instance; the datapath itself is external and combinational.

Parameters:
- LEN_W, 8: width of cmd_len and r_count; max burst 2^LEN_W-1 samples.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00=MAXABS, 01=MIN, 10=MAX, 11=reserved.
- cmd_len  in  LEN_W  number of samples in the burst.
- s_valid  in  1  sample offered.
- s_ready  out  1  sample accepted this cycle when s_valid also high.
- s_data  in  16  sample.
- r_valid  out  1  result available.
- r_ready  in  1  result consumer ready.
- r_data  out  16  reduction result.
- r_count  out  LEN_W  samples consumed.
- r_err  out  1  reserved op was issued.
- dp_a  out  16  datapath operand A.
- dp_b  out  16  datapath operand B.
- dp_c  out  2  datapath op code.
- dp_out  in  16  datapath result, combinational from dp_a/dp_b/dp_c.

Behaviour:
- Datapath semantics:
  - c=00 gives two's complement abs of B (0x8000 -> 0x8000).
  - c=01 gives unsigned min(A,B).
  - c=10 gives unsigned max(A,B).
  - c=11 gives high-Z; dp_out is ignored whenever the sequencer drives 11.
- FSM states: IDLE, RUN, MAXC, DONE. cmd_ready, s_ready and r_valid are decoded from registered state only; there is no combinational input-to-ready path.
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, tmp=0, remaining=0, r_count=0, r_err=0, op=00.
  - dp_a=0, dp_b=0, dp_c=11.
  - Reset mid-burst aborts: partial result discarded, no r_valid, unconsumed samples left in the source.
- IDLE:
  - cmd_ready=1; dp_c=11.
  - On cmd_valid, latch op and len; clear r_count and r_err.
  - acc init: MIN=0xFFFF, MAX=0x0000, MAXABS=0x0000.
  - op=11: r_err=1, acc=0, go to DONE.
  - len=0: go to DONE with the init value.
  - Otherwise: remaining=len, go to RUN.
- RUN, op MIN/MAX:
  - s_ready=1; dp_a=acc, dp_b=s_data, dp_c=op.
  - On handshake: acc<=dp_out, r_count++, remaining--.
  - If remaining was 1, go to DONE.
  - Throughput: 1 sample/cycle.
- RUN, op MAXABS:
  - s_ready=1; dp_b=s_data, dp_c=00.
  - On handshake: tmp<=dp_out, r_count++, go to MAXC.
- MAXC:
  - s_ready=0; dp_a=acc, dp_b=tmp, dp_c=10; acc<=dp_out, remaining--.
  - Go to DONE if remaining was 1, else back to RUN.
  - Throughput: 1 sample per 2 cycles.
- Stalls: no handshake in RUN means acc, r_count and remaining are held; dp_* still track s_data.
- DONE:
  - r_valid=1; r_data=acc; dp_c=11.
  - r_data, r_count and r_err are held stable until r_ready.
  - On r_ready, go to IDLE; a new command can be accepted in the following cycle.
- Latency: r_valid rises the cycle after the last accumulate, i.e. after the final RUN handshake for MIN/MAX, or after the final MAXC cycle for MAXABS.
- Datapath idle: dp_c=11 in IDLE and DONE.
- Width rules: all data paths are 16 bits, with no sign extension or saturation. r_count saturates only by construction, since it is never greater than len.
- cmd_valid outside IDLE is ignored (cmd_ready=0). s_valid outside RUN is not consumed.

Test Plan:
- MAX, len=3, samples 0x0003, 0x8000, 0x0010 back-to-back -> r_data=0x8000, r_count=3, r_valid on the cycle after the third handshake, r_err=0.
- MIN over the same samples, with s_valid dropped for 2 cycles between the 1st and 2nd sample -> r_data=0x0003; acc unchanged during the gap.
- MAXABS, len=3, samples 0x0005, 0xFFF0, 0x0007 -> r_data=0x0010, r_count=3.
  - s_ready pattern 1,0,1,0,1.
  - dp_c alternates 00/10 while active.
  - r_valid no earlier than 6 cycles after the first handshake.
- len=0 with op MIN -> r_data=0xFFFF, r_count=0, no sample consumed; reserved op 11 with len=5 -> r_err=1, r_data=0x0000, s_ready never asserted.
- Backpressure: hold r_ready=0 for 4 cycles in DONE -> r_data/r_count/r_err stable, cmd_ready=0, a new cmd_valid is not accepted until the cycle after the r_ready handshake.
- Assert rst_n=0 after 2 of 4 MAX samples -> all outputs return to reset values immediately; after release, a new len=1 MAX of 0x1234 -> r_data=0x1234, r_count=1.
